rf_wr_arbiter: RTL

- Shares the single write port of the 8x16b bypassed register file between NREQ independent producers, e.g. ALU writeback, load return and a debug/config poke.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Has one registered output stage that drives writeRegSel/writeData/writeEn directly.
- Supports a stall input, so the port can be lent out while a granted write is held, and a flush.

---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_wr_arbiter_rr_arb_core.sv | 34 +++
 rtl/rf_wr_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-port request record.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rf_pkg;

  localparam int RF_ADDR_W = 3;
  localparam int RF_DATA_W = 16;
  localparam int RF_NREGS  = 8;

  // One pending register-file write, as held by a write-port output stage
  typedef struct packed {
    logic                 vld;
    logic [RF_ADDR_W-1:0] sel;
    logic [RF_DATA_W-1:0] dat;
  } rfWr_t;

  // Round-robin successor of a grant index, wrapping at nreq
  function automatic int rrNext(input int idx, input int nreq);
    return (idx + 1) % nreq;
  endfunction

endpackage

// File: rtl/rf_wr_arbiter_rr_arb_core.sv
// Round-robin grant generator: first asserted request at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational, gnt/idx follow req/ptr/en in the same cycle.
// Backpressure: en=0 forces an all-zero grant; the caller owns the pointer register.
module rr_arb_core #(
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan requesters starting at ptr and grant the first one that is valid
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NREQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin sharing of the single RF write port among NREQ producers; optional per-requester
// grant counters under RF_WR_ARB_PERF_CNT_EN. Latency: write hits the RF one cycle after handshake.
// Backpressure: wr_stall/flush withhold req_ready; wr_stall freezes the output stage and writeEn.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_sel,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wr_stall,
  input  logic                     flush,
  output logic [ADDR_W-1:0]        writeRegSel,
  output logic [DATA_W-1:0]        writeData,
  output logic                     writeEn,
  output logic [(1<<ADDR_W)-1:0]   pending_mask
`ifdef RF_WR_ARB_PERF_CNT_EN
  ,
  output logic [NREQ*16-1:0]       grant_cnt
`endif
);

  localparam int PTR_W = $clog2(NREQ);

  logic              outVld;
  logic [ADDR_W-1:0] outSel;
  logic [DATA_W-1:0] outData;
  logic [PTR_W-1:0]  ptr;

  logic              canGrant;
  logic [NREQ-1:0]   gnt;
  logic [PTR_W-1:0]  gntIdx;
  logic              anyGnt;

  // Grants are only issued when the stage can accept a write; reset also blocks them so
  // req_ready reads zero while reset is held
  assign canGrant = ~wr_stall & ~flush & rst;

  rr_arb_core #(
    .NREQ  (NREQ),
    .IDX_W (PTR_W)
  ) u_rrArb (
    .req (req_valid),
    .ptr (ptr),
    .en  (canGrant),
    .gnt (gnt),
    .idx (gntIdx)
  );

  assign anyGnt    = |gnt;
  assign req_ready = gnt;

  // The held write drains whenever the port is not lent out
  assign writeEn     = outVld & ~wr_stall;
  assign writeRegSel = outSel;
  assign writeData   = outData;

  // Output stage: flush clears, a grant refills, a drained write without a refill empties
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outVld  <= 1'b0;
      outSel  <= '0;
      outData <= '0;
    end else if (flush) begin
      outVld <= 1'b0;
    end else if (anyGnt) begin
      outVld  <= 1'b1;
      outSel  <= req_sel[gntIdx*ADDR_W +: ADDR_W];
      outData <= req_data[gntIdx*DATA_W +: DATA_W];
    end else if (writeEn) begin
      outVld <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the winner, and only on a grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (anyGnt) begin
      ptr <= PTR_W'(rrNext(int'(gntIdx), NREQ));
    end
  end

  // Flag the destination still sitting in the stage so readers can see it is not committed yet
  always_comb begin
    pending_mask = '0;
    if (outVld) begin
      pending_mask[outSel] = 1'b1;
    end
  end

`ifdef RF_WR_ARB_PERF_CNT_EN
  logic [15:0] grantCnt [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    // Saturating handshake count per requester, cleared by flush
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        grantCnt[i] <= '0;
      end else if (flush) begin
        grantCnt[i] <= '0;
      end else if (gnt[i] && (grantCnt[i] != 16'hFFFF)) begin
        grantCnt[i] <= grantCnt[i] + 16'd1;
      end
    end

    assign grant_cnt[i*16 +: 16] = grantCnt[i];
  end
`endif

endmodule
